// File: rtl/mseq_pkg.sv
// Shared types and constants for the LDM/STM/PUSH/POP micro-sequencer.
package mseq_pkg;

    typedef enum logic [1:0] {
        OP_STM  = 2'd0,
        OP_LDM  = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } mseq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } mseq_state_t;

    localparam logic [6:0] OPC_STORE_MULTIPLE = 7'b1100_000;
    localparam logic [6:0] OPC_LOAD_MULTIPLE  = 7'b1100_100;
    localparam logic [3:0] LR_IDX = 4'd14;
    localparam logic [3:0] PC_IDX = 4'd15;

    function automatic logic is_load(input mseq_op_t o);
        return (o == OP_LDM) || (o == OP_POP);
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: position of the lowest set bit of a 9-bit register mask.
module lowest_set_bit (
    input  logic [8:0] mask_i,
    output logic [3:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int k = 8; k >= 0; k--) begin
            if (mask_i[k]) begin
                idx_o   = 4'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: one data_mem word access per listed register,
// pipelined load writeback, and a single base/SP writeback on completion.
module ldm_stm_sequencer
    import mseq_pkg::*;
#(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned SP_IDX    = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  base_idx,
    input  logic [31:0] base_addr,
    input  logic [8:0]  reg_list,
    input  logic        wb_en,
    output logic [3:0]  rf_rd_idx,
    input  logic [31:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [3:0]  rf_wr_idx,
    output logic [31:0] rf_wr_data,
    output logic [6:0]  mem_opcode,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        base_wr_en,
    output logic [3:0]  base_wr_idx,
    output logic [31:0] base_wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] STEP   = 32'(ADDR_STEP);
    localparam logic [3:0]  SP_REG = 4'(SP_IDX);

    mseq_state_t state_q;
    mseq_op_t    op_q;
    logic [8:0]  mask_q;
    logic [31:0] addr_q;
    logic        ld_pend_q;
    logic [3:0]  ld_idx_q;
    logic        wb_en_q;
    logic [3:0]  wb_idx_q;
    logic [31:0] wb_data_q;

    mseq_op_t    op_in;
    logic [3:0]  n_regs;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [31:0] new_base;
    logic        base_in_list;
    logic        wb_req;
    logic [3:0]  lsb_pos;
    logic        lsb_valid;
    logic [3:0]  cur_reg;
    logic [8:0]  mask_d;
    logic        issuing;

    assign op_in = mseq_op_t'(op);

    always_comb begin
        n_regs = '0;
        for (int k = 0; k < 9; k++) begin
            n_regs = n_regs + {3'd0, reg_list[k]};
        end
    end

    assign span       = STEP * {28'd0, n_regs};
    assign start_addr = (op_in == OP_PUSH) ? (base_addr - span) : base_addr;
    assign new_base   = (op_in == OP_PUSH) ? start_addr : (base_addr + span);

    // Only r0..r7 can appear in an LDM list, so a high base index never self-loads.
    assign base_in_list = !base_idx[3] && reg_list[base_idx[2:0]];
    assign wb_req       = op_in[1] || (wb_en && !((op_in == OP_LDM) && base_in_list));

    lowest_set_bit u_lsb (
        .mask_i  (mask_q),
        .idx_o   (lsb_pos),
        .valid_o (lsb_valid)
    );

    assign cur_reg = (lsb_pos == 4'd8) ? ((op_q == OP_POP) ? PC_IDX : LR_IDX) : lsb_pos;
    assign mask_d  = mask_q & (mask_q - 9'd1);
    assign issuing = (state_q == ST_ISSUE) && lsb_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_STM;
            mask_q    <= '0;
            addr_q    <= '0;
            ld_pend_q <= 1'b0;
            ld_idx_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
        end else begin
            ld_pend_q <= issuing && is_load(op_q);
            ld_idx_q  <= cur_reg;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op_in;
                        mask_q    <= reg_list;
                        addr_q    <= start_addr;
                        wb_en_q   <= wb_req && (reg_list != 9'd0);
                        wb_idx_q  <= op_in[1] ? SP_REG : base_idx;
                        wb_data_q <= new_base;
                        state_q   <= (reg_list != 9'd0) ? ST_ISSUE : ST_DRAIN;
                    end
                end
                ST_ISSUE: begin
                    addr_q <= addr_q + STEP;
                    mask_q <= mask_d;
                    if (mask_d == 9'd0) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    wb_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Opcode is presented from the accept cycle so data_mem has its access size ready.
    always_comb begin
        mem_opcode = '0;
        if (state_q != ST_IDLE) begin
            mem_opcode = is_load(op_q) ? OPC_LOAD_MULTIPLE : OPC_STORE_MULTIPLE;
        end else if (start) begin
            mem_opcode = is_load(op_in) ? OPC_LOAD_MULTIPLE : OPC_STORE_MULTIPLE;
        end
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DRAIN);
        mem_addr     = issuing ? addr_q : '0;
        mem_write_en = issuing && !is_load(op_q);
        rf_rd_idx    = mem_write_en ? cur_reg : '0;
        mem_wdata    = mem_write_en ? rf_rd_data : '0;
        rf_wr_en     = ld_pend_q;
        rf_wr_idx    = ld_pend_q ? ld_idx_q : '0;
        rf_wr_data   = ld_pend_q ? mem_rdata : '0;
        base_wr_en   = done && wb_en_q;
        base_wr_idx  = base_wr_en ? wb_idx_q : '0;
        base_wr_data = base_wr_en ? wb_data_q : '0;
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: table of multi-register ops checked through a cycle-stamped scoreboard.
module tb_ldm_stm_sequencer;

    localparam logic [1:0] B_STM  = 2'd0;
    localparam logic [1:0] B_LDM  = 2'd1;
    localparam logic [1:0] B_PUSH = 2'd2;
    localparam logic [1:0] B_POP  = 2'd3;
    localparam logic [6:0] B_OPC_ST = 7'b1100000;
    localparam logic [6:0] B_OPC_LD = 7'b1100100;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  base_idx;
        logic [31:0] base;
        logic [8:0]  list;
        logic        wb_en;
        logic [31:0] exp_start;
        logic        exp_wb;
        logic [3:0]  exp_wb_idx;
        logic [31:0] exp_wb_data;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic [6:0]  opc;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  base_idx;
    logic [31:0] base_addr;
    logic [8:0]  reg_list;
    logic        wb_en;
    logic [3:0]  rf_rd_idx;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic [6:0]  mem_opcode;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        base_wr_en;
    logic [3:0]  base_wr_idx;
    logic [31:0] base_wr_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ldm_stm_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .base_idx     (base_idx),
        .base_addr    (base_addr),
        .reg_list     (reg_list),
        .wb_en        (wb_en),
        .rf_rd_idx    (rf_rd_idx),
        .rf_rd_data   (rf_rd_data),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_idx    (rf_wr_idx),
        .rf_wr_data   (rf_wr_data),
        .mem_opcode   (mem_opcode),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .base_wr_en   (base_wr_en),
        .base_wr_idx  (base_wr_idx),
        .base_wr_data (base_wr_data),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_lo = 1;
    int busy_hi = 0;

    acc_t acc_q[$];
    wr_t  rf_q[$];
    wr_t  base_q[$];
    int   done_q[$];

    logic [31:0] mdl_rf  [0:15];
    logic [31:0] mdl_mem [0:255];
    logic [31:0] env_rf  [0:15];
    logic [31:0] env_mem [0:255];
    bit          env_init = 1'b0;

    function automatic logic [31:0] rf_init(input int i);
        if (i == 0) return 32'h0000_00A5;
        if (i == 1) return 32'h0000_0040;
        if (i == 5) return 32'hDEAD_BEEF;
        return 32'h0BAD_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] mem_init(input int i);
        return 32'hCAFE_0000 | 32'(i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: register file and data_mem with one-cycle registered read.
    assign rf_rd_data = env_rf[rf_rd_idx];
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 16; i++) env_rf[i] <= rf_init(i);
            for (int i = 0; i < 256; i++) env_mem[i] <= mem_init(i);
            env_init <= 1'b1;
        end else begin
            if (mem_write_en) env_mem[widx(mem_addr)] <= mem_wdata;
            mem_rdata <= env_mem[widx(mem_addr)];
            if (rf_wr_en) env_rf[rf_wr_idx] <= rf_wr_data;
            if (base_wr_en) env_rf[base_wr_idx] <= base_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: pop expectations whose cycle stamp matches; any unexpected strobe is an error.
    always @(negedge clk) begin
        acc_t a;
        wr_t  w;
        if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
            a = acc_q.pop_front();
            chk("acc_addr", mem_addr, a.addr);
            chk("acc_we", 32'(mem_write_en), 32'(a.we));
            chk("acc_opc", 32'(mem_opcode), 32'(a.opc));
            if (a.we) chk("acc_wdata", mem_wdata, a.data);
        end else if (mem_write_en) begin
            chk("spurious_mem_we", 32'(mem_write_en), 32'd0);
        end
        if (rf_q.size() > 0 && rf_q[0].cyc == cyc) begin
            w = rf_q.pop_front();
            chk("rf_wr_en", 32'(rf_wr_en), 32'd1);
            chk("rf_wr_idx", 32'(rf_wr_idx), 32'(w.idx));
            chk("rf_wr_data", rf_wr_data, w.data);
        end else if (rf_wr_en) begin
            chk("spurious_rf_wr", 32'(rf_wr_en), 32'd0);
        end
        if (base_q.size() > 0 && base_q[0].cyc == cyc) begin
            w = base_q.pop_front();
            chk("base_wr_en", 32'(base_wr_en), 32'd1);
            chk("base_wr_idx", 32'(base_wr_idx), 32'(w.idx));
            chk("base_wr_data", base_wr_data, w.data);
        end else if (base_wr_en) begin
            chk("spurious_base_wr", 32'(base_wr_en), 32'd0);
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            chk("done", 32'(done), 32'd1);
        end else if (done) begin
            chk("spurious_done", 32'(done), 32'd0);
        end
        chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
    end

    task automatic expect_row(input vec_t v, input int s, output int n);
        int          j;
        logic [31:0] a;
        logic [3:0]  r;
        logic        ld;
        acc_t        e;
        wr_t         w;
        n  = 0;
        j  = 0;
        ld = (v.op == B_LDM) || (v.op == B_POP);
        for (int k = 0; k < 9; k++) n += int'(v.list[k]);
        for (int k = 0; k < 9; k++) begin
            if (v.list[k]) begin
                r      = (k < 8) ? 4'(k) : ((v.op == B_POP) ? 4'd15 : 4'd14);
                a      = v.exp_start + 32'(4 * j);
                e.cyc  = s + 1 + j;
                e.addr = a;
                e.opc  = ld ? B_OPC_LD : B_OPC_ST;
                if (ld) begin
                    e.we   = 1'b0;
                    e.data = '0;
                    w.cyc  = s + 2 + j;
                    w.idx  = r;
                    w.data = mdl_mem[widx(a)];
                    rf_q.push_back(w);
                    mdl_rf[r] = w.data;
                end else begin
                    e.we   = 1'b1;
                    e.data = mdl_rf[r];
                    mdl_mem[widx(a)] = e.data;
                end
                acc_q.push_back(e);
                j++;
            end
        end
        done_q.push_back(s + n + 1);
        busy_lo = s + 1;
        busy_hi = s + n + 1;
        if (v.exp_wb) begin
            w.cyc  = s + n + 1;
            w.idx  = v.exp_wb_idx;
            w.data = v.exp_wb_data;
            base_q.push_back(w);
            mdl_rf[v.exp_wb_idx] = v.exp_wb_data;
        end
    endtask

    // Called #2 after a negedge in an idle cycle; the start is accepted at the next posedge.
    task automatic start_row(input vec_t v, output int n);
        int s;
        op        = v.op;
        base_idx  = v.base_idx;
        base_addr = v.base;
        reg_list  = v.list;
        wb_en     = v.wb_en;
        start     = 1'b1;
        s         = cyc;
        expect_row(v, s, n);
        #1;
        chk("accept_opc", 32'(mem_opcode),
            32'(((v.op == B_LDM) || (v.op == B_POP)) ? B_OPC_LD : B_OPC_ST));
    endtask

    task automatic run_row(input vec_t v, input int id);
        int n;
        $display("txn %0d: op=%0d base_idx=%0d base=%h list=%h wb_en=%0d", id, v.op, v.base_idx,
                 v.base, v.list, v.wb_en);
        start_row(v, n);
        @(negedge clk);
        #2 start = 1'b0;
        repeat (n + 1) @(negedge clk);
        #2;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_write_en), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_opc"}, 32'(mem_opcode), 32'd0);
        chk({tag, "_rf_wr_en"}, 32'(rf_wr_en), 32'd0);
        chk({tag, "_base_wr_en"}, 32'(base_wr_en), 32'd0);
        chk({tag, "_base_wr_data"}, base_wr_data, 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        int   n;
        int   s;
        vec_t v;
        acc_t e;

        vecs[0]  = '{B_PUSH, 4'd0, 32'h0000_0100, 9'h103, 1'b0, 32'h0000_00F4, 1'b1, 4'd13, 32'h0000_00F4};
        vecs[1]  = '{B_POP,  4'd0, 32'h0000_00F4, 9'h104, 1'b0, 32'h0000_00F4, 1'b1, 4'd13, 32'h0000_00FC};
        vecs[2]  = '{B_LDM,  4'd1, 32'h0000_0020, 9'h00B, 1'b1, 32'h0000_0020, 1'b0, 4'd0,  32'h0};
        vecs[3]  = '{B_STM,  4'd4, 32'h0000_0010, 9'h020, 1'b1, 32'h0000_0010, 1'b1, 4'd4,  32'h0000_0014};
        vecs[4]  = '{B_STM,  4'd2, 32'h0000_0040, 9'h000, 1'b1, 32'h0000_0040, 1'b0, 4'd0,  32'h0};
        vecs[5]  = '{B_PUSH, 4'd0, 32'h0000_0080, 9'h000, 1'b0, 32'h0000_0080, 1'b0, 4'd0,  32'h0};
        vecs[6]  = '{B_STM,  4'd6, 32'h0000_0200, 9'h0F0, 1'b0, 32'h0000_0200, 1'b0, 4'd0,  32'h0};
        vecs[7]  = '{B_LDM,  4'd2, 32'h0000_0200, 9'h081, 1'b1, 32'h0000_0200, 1'b1, 4'd2,  32'h0000_0208};
        vecs[8]  = '{B_PUSH, 4'd0, 32'h0000_0004, 9'h1C0, 1'b0, 32'hFFFF_FFF8, 1'b1, 4'd13, 32'hFFFF_FFF8};
        vecs[9]  = '{B_POP,  4'd0, 32'hFFFF_FFF8, 9'h1C0, 1'b0, 32'hFFFF_FFF8, 1'b1, 4'd13, 32'h0000_0004};
        vecs[10] = '{B_LDM,  4'd0, 32'h0000_0300, 9'h0FF, 1'b0, 32'h0000_0300, 1'b0, 4'd0,  32'h0};
        vecs[11] = '{B_STM,  4'd3, 32'h0000_0100, 9'h00C, 1'b1, 32'h0000_0100, 1'b1, 4'd3,  32'h0000_0108};
        vecs[12] = '{B_LDM,  4'd9, 32'h0000_03A0, 9'h002, 1'b1, 32'h0000_03A0, 1'b1, 4'd9,  32'h0000_03A4};

        for (int i = 0; i < 16; i++) mdl_rf[i] = rf_init(i);
        for (int i = 0; i < 256; i++) mdl_mem[i] = mem_init(i);

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        base_idx  = 4'd0;
        base_addr = 32'd0;
        reg_list  = 9'd0;
        wb_en     = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        #2;

        for (int i = 0; i < 13; i++) run_row(vecs[i], i);

        // Start held high while busy, with the inputs changed under it: must be ignored.
        v = '{B_STM, 4'd8, 32'h0000_03C0, 9'h003, 1'b0, 32'h0000_03C0, 1'b0, 4'd0, 32'h0};
        $display("txn b2b: STM list=%h base=%h with start held", v.list, v.base);
        start_row(v, n);
        @(negedge clk);
        #2;
        op        = B_LDM;
        reg_list  = 9'h0FF;
        base_addr = 32'h0000_0000;
        repeat (n) @(negedge clk);
        #2 start = 1'b0;
        repeat (3) @(negedge clk);
        #2;

        // Reset asserted in cycle 2 of a 4-register STM.
        $display("txn rst: STM list=00f base=00000380 reset at cycle 2");
        op        = B_STM;
        base_idx  = 4'd9;
        base_addr = 32'h0000_0380;
        reg_list  = 9'h00F;
        wb_en     = 1'b1;
        start     = 1'b1;
        s         = cyc;
        for (int j = 0; j < 2; j++) begin
            e.cyc  = s + 1 + j;
            e.addr = 32'h0000_0380 + 32'(4 * j);
            e.we   = 1'b1;
            e.data = mdl_rf[j];
            e.opc  = B_OPC_ST;
            mdl_mem[widx(e.addr)] = e.data;
            acc_q.push_back(e);
        end
        busy_lo = s + 1;
        busy_hi = s + 2;
        @(negedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;

        chk("acc_q_empty", 32'(acc_q.size()), 32'd0);
        chk("rf_q_empty", 32'(rf_q.size()), 32'd0);
        chk("base_q_empty", 32'(base_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
